// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants for the BRAM port arbiter: default BRAM geometry and the
// requester-index width, which is sized for the largest supported requester count.
package bram_port_arbiter_pkg;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int MAX_REQ        = 4;
  localparam int REQ_IDX_W      = $clog2(MAX_REQ);

  // Successor index; wraps at n, not at 2**REQ_IDX_W.
  function automatic logic [REQ_IDX_W-1:0] rr_next(input logic [REQ_IDX_W-1:0] idx,
                                                   input int n);
    int t;
    t = int'(idx) + 1;
    if (t >= n) t = 0;
    return t[REQ_IDX_W-1:0];
  endfunction
endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter over N requesters. The search starts at the internal pointer.
// The pointer moves past the winner only when the parent asserts advance.
module rr_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [REQ_IDX_W-1:0] gnt_idx
);
  logic [REQ_IDX_W-1:0] r_ptr;
  logic                 w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    for (int o = 0; o < N; o++) begin
      for (int k = 0; k < N; k++) begin
        if (!w_found && req[k] && (k == (int'(r_ptr) + o) % N)) begin
          w_found = 1'b1;
          gnt[k]  = 1'b1;
          gnt_idx = REQ_IDX_W'(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          r_ptr <= '0;
    else if (advance) r_ptr <= rr_next(gnt_idx, N);
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple dual-port BRAM among NUM_REQ requesters. Writes and reads are
// arbitrated independently, and read data returns one cycle after grant.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          bram_rst_n,
  output logic                          bram_ena,
  output logic [ADDR_WIDTH-1:0]         bram_addra,
  output logic [DATA_WIDTH-1:0]         bram_dina,
  output logic                          bram_enb,
  output logic [ADDR_WIDTH-1:0]         bram_addrb,
  input  logic [DATA_WIDTH-1:0]         bram_doutb
);
  logic [NUM_REQ-1:0]   w_wr_cand, w_rd_cand, w_wr_gnt, w_rd_gnt;
  logic [REQ_IDX_W-1:0] w_wr_idx, w_rd_idx;
  logic [ADDR_WIDTH-1:0] w_waddr, w_raddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                 w_wr_any, w_rd_any, w_hazard, w_wr_go, w_rd_go;
  logic [NUM_REQ-1:0]   r_rsp_owner;

  assign w_wr_cand = req_valid & req_we;
  assign w_rd_cand = req_valid & ~req_we;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk(clk), .rst(rst), .req(w_wr_cand), .advance(w_wr_go),
    .gnt(w_wr_gnt), .gnt_idx(w_wr_idx)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk(clk), .rst(rst), .req(w_rd_cand), .advance(w_rd_go),
    .gnt(w_rd_gnt), .gnt_idx(w_rd_idx)
  );

  always_comb begin
    w_waddr = '0;
    w_wdata = '0;
    w_raddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_wr_idx == REQ_IDX_W'(i)) begin
        w_waddr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (w_rd_idx == REQ_IDX_W'(i)) w_raddr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign w_wr_any = |w_wr_gnt;
  assign w_rd_any = |w_rd_gnt;
  // A same-address read yields to the write so it sees the new data on retry.
  assign w_hazard = w_wr_any & w_rd_any & (w_waddr == w_raddr);
  assign w_wr_go  = w_wr_any & ~rst;
  assign w_rd_go  = w_rd_any & ~w_hazard & ~rst;

  assign req_ready  = ({NUM_REQ{w_wr_go}} & w_wr_gnt) | ({NUM_REQ{w_rd_go}} & w_rd_gnt);
  assign bram_rst_n = ~rst;
  assign bram_ena   = w_wr_go;
  assign bram_addra = w_waddr;
  assign bram_dina  = w_wdata;
  assign bram_enb   = w_rd_go;
  assign bram_addrb = w_raddr;
  assign rsp_rdata  = bram_doutb;

  always_ff @(posedge clk) begin
    if (rst) r_rsp_owner <= '0;
    else     r_rsp_owner <= {NUM_REQ{w_rd_go}} & w_rd_gnt;
  end

  // Reset also kills a response that is already in flight.
  assign rsp_valid = rst ? '0 : r_rsp_owner;
endmodule
